// File: rtl/mult_pkg.sv
// Shared types and arbitration helpers for the shared Booth multiplier.
// Pick functions work on a MAX_REQ-wide request vector so one definition serves every NUM_REQ.
package mult_pkg;

   localparam int MULT_W    = 7;
   localparam int MAX_REQ   = 8;
   localparam int MAX_IDX_W = 3;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_e;

   // Search order is ptr, ptr+1, ... wrapping at num_req. Walking the order backwards
   // lets the last hit (the earliest in search order) win without a break.
   function automatic logic [MAX_IDX_W-1:0] rr_pick(input logic [MAX_REQ-1:0]   req,
                                                    input logic [MAX_IDX_W-1:0] ptr,
                                                    input int                   num_req);
      logic [MAX_IDX_W-1:0] idx;
      rr_pick = ptr;
      for (int k = MAX_REQ - 1; k >= 0; k--) begin
         if (k < num_req) begin
            idx = MAX_IDX_W'((int'(ptr) + k) % num_req);
            if (req[idx]) rr_pick = idx;
         end
      end
   endfunction

   function automatic logic [MAX_IDX_W-1:0] prio_pick(input logic [MAX_REQ-1:0] req);
      prio_pick = '0;
      for (int k = MAX_REQ - 1; k >= 0; k--) begin
         if (req[k]) prio_pick = MAX_IDX_W'(k);
      end
   endfunction

endpackage

// File: rtl/booth_mult_engine.sv
// Sequential radix-2 Booth datapath: A (multiplicand), P (partial product), B (multiplier + guard bit).
// 'product' is the value {P,B} will hold after the step being taken this cycle.
module booth_mult_engine
   import mult_pkg::*;
#(
   parameter int W = MULT_W
)
(
   input  logic           clk,
   input  logic           load,
   input  logic           step,
   input  logic [W-1:0]   a,
   input  logic [W-1:0]   b,
   output logic [2*W-1:0] product
);

   logic [W:0] a_q, a_d;
   logic [W:0] p_q, p_d;
   logic [W:0] b_q, b_d;
   logic [W:0] sum;
   logic [W:0] p_sh;
   logic [W:0] b_sh;

   // A is sign-extended to W+1 bits so that -2^(W-1) negates without overflow.
   always_comb begin
      case (b_q[1:0])
         2'b01:   sum = p_q + a_q;
         2'b10:   sum = p_q - a_q;
         default: sum = p_q;
      endcase
      p_sh = {sum[W], sum[W:1]};
      b_sh = {sum[0], b_q[W:1]};

      // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
      a_d = a_q;
      p_d = p_q;
      b_d = b_q;
      if (load) begin
         a_d = {a[W-1], a};
         p_d = '0;
         b_d = {b, 1'b0};
      end else if (step) begin
         p_d = p_sh;
         b_d = b_sh;
      end
   end

   assign product = {p_sh[W-1:0], b_sh[W:1]};

   // NOTE: pure datapath registers are left without reset; they are always loaded before use.
   always_ff @(posedge clk) begin
      a_q <= a_d;
      p_q <= p_d;
      b_q <= b_d;
   end

endmodule

// File: rtl/mult_share_arbiter.sv
// Arbitrates NUM_REQ clients onto one Booth multiplier: IDLE -> RUN (W steps) -> DONE (ack pulse).
// Build option ARB_FIXED_PRIO_EN: lowest-index-wins arbitration instead of round-robin.
module mult_share_arbiter
   import mult_pkg::*;
#(
   parameter  int NUM_REQ = 4,
   parameter  int W       = MULT_W,
   localparam int ID_W    = $clog2(NUM_REQ)
)
(
   input  logic                 clk,
   input  logic                 reset,
   input  logic [NUM_REQ-1:0]   req,
   input  logic [NUM_REQ*W-1:0] a_value,
   input  logic [NUM_REQ*W-1:0] b_value,
   output logic [NUM_REQ-1:0]   ack,
   output logic                 resp_valid,
   output logic [ID_W-1:0]      resp_id,
   output logic [2*W-1:0]       result,
   output logic                 busy
);

   localparam int CNT_W = $clog2(W + 1);

   state_e               state_q, state_d;
   logic [CNT_W-1:0]     cnt_q, cnt_d;
   logic [ID_W-1:0]      gnt_q, gnt_d;
   logic [NUM_REQ-1:0]   ack_q, ack_d;
   logic                 resp_valid_q, resp_valid_d;
   logic [ID_W-1:0]      resp_id_q, resp_id_d;
   logic [2*W-1:0]       result_q, result_d;
   logic                 busy_q, busy_d;

   logic [ID_W-1:0]      pick;
   logic [W-1:0]         a_sel;
   logic [W-1:0]         b_sel;
   logic                 eng_load;
   logic                 eng_step;
   logic [2*W-1:0]       eng_product;

`ifdef ARB_FIXED_PRIO_EN
   always_comb pick = ID_W'(prio_pick(MAX_REQ'(req)));
`else
   logic [ID_W-1:0]      ptr_q, ptr_d;

   always_comb pick = ID_W'(rr_pick(MAX_REQ'(req), MAX_IDX_W'(ptr_q), NUM_REQ));
`endif

   assign a_sel = a_value[pick*W +: W];
   assign b_sel = b_value[pick*W +: W];

   booth_mult_engine #(.W(W)) u_engine (
      .clk     (clk),
      .load    (eng_load),
      .step    (eng_step),
      .a       (a_sel),
      .b       (b_sel),
      .product (eng_product)
   );

   always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_q;
      gnt_d        = gnt_q;
      ack_d        = '0;
      resp_valid_d = 1'b0;
      resp_id_d    = resp_id_q;
      result_d     = result_q;
      eng_load     = 1'b0;
      eng_step     = 1'b0;
`ifndef ARB_FIXED_PRIO_EN
      ptr_d        = ptr_q;
`endif

      case (state_q)
         IDLE: begin
            if (|req) begin
               eng_load = 1'b1;
               gnt_d    = pick;
               cnt_d    = '0;
               state_d  = RUN;
`ifndef ARB_FIXED_PRIO_EN
               ptr_d    = (pick == ID_W'(NUM_REQ - 1)) ? '0 : pick + 1'b1;
`endif
            end
         end
         RUN: begin
            eng_step = 1'b1;
            cnt_d    = cnt_q + 1'b1;
            // The last step's result is captured on the same edge that enters DONE,
            // so ack and result become visible together.
            if (cnt_q == CNT_W'(W - 1)) begin
               state_d      = DONE;
               ack_d        = NUM_REQ'(1) << gnt_q;
               resp_valid_d = 1'b1;
               resp_id_d    = gnt_q;
               result_d     = eng_product;
            end
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase

      busy_d = (state_d != IDLE);
   end

   // NOTE: sequential state uses non-blocking assignment so all flops update from pre-edge values.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= IDLE;
         cnt_q        <= '0;
         gnt_q        <= '0;
         ack_q        <= '0;
         resp_valid_q <= 1'b0;
         resp_id_q    <= '0;
         result_q     <= '0;
         busy_q       <= 1'b0;
`ifndef ARB_FIXED_PRIO_EN
         ptr_q        <= '0;
`endif
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         gnt_q        <= gnt_d;
         ack_q        <= ack_d;
         resp_valid_q <= resp_valid_d;
         resp_id_q    <= resp_id_d;
         result_q     <= result_d;
         busy_q       <= busy_d;
`ifndef ARB_FIXED_PRIO_EN
         ptr_q        <= ptr_d;
`endif
      end
   end

   assign ack        = ack_q;
   assign resp_valid = resp_valid_q;
   assign resp_id    = resp_id_q;
   assign result     = result_q;
   assign busy       = busy_q;

endmodule

// File: tb/tb_mult_share_arbiter.sv
// Self-checking bench for mult_share_arbiter: directed products, arbitration order,
// mid-op reset, operand/req changes after grant, and randomized traffic against a model.
module tb_mult_share_arbiter;

   localparam int NUM_REQ = 4;
   localparam int W       = 7;
   localparam int ID_W    = 2;
   localparam int PW      = 2 * W;
   localparam int BOUND   = 40;

   logic                 clk;
   logic                 reset;
   logic [NUM_REQ-1:0]   req;
   logic [NUM_REQ*W-1:0] a_value;
   logic [NUM_REQ*W-1:0] b_value;
   logic [NUM_REQ-1:0]   ack;
   logic                 resp_valid;
   logic [ID_W-1:0]      resp_id;
   logic [PW-1:0]        result;
   logic                 busy;

   int checks = 0;
   int errors = 0;
   int model_ptr = 0;
   int a_op [NUM_REQ];
   int b_op [NUM_REQ];

   mult_share_arbiter #(.NUM_REQ(NUM_REQ), .W(W)) dut (
      .clk        (clk),
      .reset      (reset),
      .req        (req),
      .a_value    (a_value),
      .b_value    (b_value),
      .ack        (ack),
      .resp_valid (resp_valid),
      .resp_id    (resp_id),
      .result     (result),
      .busy       (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference model: arbitration by the stated search rule, product by integer multiply.
   function automatic int model_pick(input logic [NUM_REQ-1:0] r, input int ptr);
`ifdef ARB_FIXED_PRIO_EN
      for (int i = 0; i < NUM_REQ; i++) if (r[i]) return i;
`else
      for (int k = 0; k < NUM_REQ; k++) if (r[(ptr + k) % NUM_REQ]) return (ptr + k) % NUM_REQ;
`endif
      return -1;
   endfunction

   function automatic logic [PW-1:0] model_prod(input int a, input int b);
      return PW'(a * b);
   endfunction

   function automatic int rand_op();
      return int'($urandom_range(127)) - 64;
   endfunction

   task automatic set_op(input int i, input int a, input int b);
      a_op[i] = a;
      b_op[i] = b;
      a_value[i*W +: W] = W'(a);
      b_value[i*W +: W] = W'(b);
   endtask

   task automatic do_reset();
      reset = 1'b1;
      req   = '0;
      @(posedge clk); #1;
      @(posedge clk); #1;
      reset = 1'b0;
      model_ptr = 0;
   endtask

   task automatic wait_resp(input string tag, output int n);
      n = 0;
      do begin
         @(posedge clk); #1;
         n++;
      end while (resp_valid !== 1'b1 && n < BOUND);
      checks++;
      if (resp_valid !== 1'b1) begin
         errors++;
         $display("FAIL %s timeout: resp_valid not seen within %0d cycles", tag, n);
      end
   endtask

   task automatic expect_resp(input string tag, input int w, input logic [PW-1:0] exp,
                              input int n, input int exp_n);
      logic [NUM_REQ-1:0] exp_ack;
      exp_ack = '0;
      exp_ack[w] = 1'b1;
      checks++;
      if (ack !== exp_ack) begin
         errors++;
         $display("FAIL %s ack: got %b expected %b", tag, ack, exp_ack);
      end
      checks++;
      if (resp_id !== ID_W'(w)) begin
         errors++;
         $display("FAIL %s resp_id: got %0d expected %0d", tag, resp_id, w);
      end
      checks++;
      if (result !== exp) begin
         errors++;
         $display("FAIL %s result: got %0d expected %0d", tag, $signed(result), $signed(exp));
      end
      checks++;
      if (n != exp_n) begin
         errors++;
         $display("FAIL %s latency: got %0d cycles expected %0d", tag, n, exp_n);
      end
   endtask

   // One request from IDLE; busy must stay high through RUN and DONE and drop afterwards.
   task automatic single_op(input string tag, input int idx, input int a, input int b);
      int w;
      int n;
      int busy_bad;
      logic [PW-1:0] exp;
      set_op(idx, a, b);
      req = '0;
      req[idx] = 1'b1;
      w = model_pick(req, model_ptr);
      exp = model_prod(a_op[w], b_op[w]);
      model_ptr = (w + 1) % NUM_REQ;
      n = 0;
      busy_bad = 0;
      do begin
         @(posedge clk); #1;
         n++;
         if (busy !== 1'b1) busy_bad++;
      end while (resp_valid !== 1'b1 && n < BOUND);
      req[idx] = 1'b0;
      expect_resp(tag, w, exp, n, W + 1);
      checks++;
      if (busy_bad != 0) begin
         errors++;
         $display("FAIL %s busy: low in %0d of %0d active cycles, expected 0", tag, busy_bad, n);
      end
      @(posedge clk); #1;
      checks++;
      if ({ack, resp_valid, busy} !== '0 || result !== exp) begin
         errors++;
         $display("FAIL %s after_ack: ack=%b resp_valid=%b busy=%b result=%0d expected 0/0/0/%0d",
                  tag, ack, resp_valid, busy, $signed(result), $signed(exp));
      end
   endtask

   task automatic test_reset();
      for (int i = 0; i < NUM_REQ; i++) set_op(i, rand_op(), rand_op());
      reset = 1'b1;
      req = '1;
      @(posedge clk); #1;
      @(posedge clk); #1;
      checks++;
      if ({ack, resp_valid, resp_id, result, busy} !== '0) begin
         errors++;
         $display("FAIL reset_state: ack=%b resp_valid=%b resp_id=%0d result=%0d busy=%b expected all 0",
                  ack, resp_valid, resp_id, result, busy);
      end
      req = '0;
      reset = 1'b0;
      model_ptr = 0;
   endtask

   task automatic test_products();
      single_op("mul_m8_m5",   0,  -8,  -5);
      single_op("mul_min_min", 0, -64, -64);
      single_op("mul_63_min",  0,  63, -64);
      single_op("mul_5_m11",   0,   5, -11);
      single_op("mul_0_m1",    0,   0,  -1);
      single_op("mul_min_63",  2, -64,  63);
      single_op("mul_m1_m1",   3,  -1,  -1);
   endtask

   // Requesters in 'pattern' stay pending and reissue immediately with fresh operands.
   task automatic test_arbitration(input string tag, input logic [NUM_REQ-1:0] pattern, input int count);
      int w;
      int n;
      logic [PW-1:0] exp;
      do_reset();
      for (int i = 0; i < NUM_REQ; i++) set_op(i, rand_op(), rand_op());
      req = pattern;
      for (int k = 0; k < count; k++) begin
         w = model_pick(req, model_ptr);
         exp = model_prod(a_op[w], b_op[w]);
         model_ptr = (w + 1) % NUM_REQ;
         wait_resp(tag, n);
         expect_resp(tag, w, exp, n, (k == 0) ? W + 1 : W + 2);
         set_op(w, rand_op(), rand_op());
      end
      req = '0;
      @(posedge clk); #1;
   endtask

   task automatic test_reset_mid_run();
      int seen;
      do_reset();
      single_op("pre_reset_op", 3, -7, 9);
      set_op(0, 20, -3);
      req = 4'b0001;
      repeat (3) begin
         @(posedge clk); #1;
      end
      reset = 1'b1;
      req = '0;
      @(posedge clk); #1;
      checks++;
      if ({ack, resp_valid, resp_id, result, busy} !== '0) begin
         errors++;
         $display("FAIL mid_run_reset: ack=%b resp_valid=%b resp_id=%0d result=%0d busy=%b expected all 0",
                  ack, resp_valid, resp_id, $signed(result), busy);
      end
      reset = 1'b0;
      model_ptr = 0;
      seen = 0;
      repeat (12) begin
         @(posedge clk); #1;
         if (ack !== '0 || resp_valid !== 1'b0) seen++;
      end
      checks++;
      if (seen != 0) begin
         errors++;
         $display("FAIL discarded_op: response seen in %0d cycles after reset, expected 0", seen);
      end
      single_op("post_reset_3x3", 1, 3, 3);
   endtask

   // Winner drops req and changes operands right after its grant edge.
   task automatic test_drop_after_grant();
      int w;
      int w2;
      int n;
      logic [PW-1:0] exp;
      set_op(0, -30, 4);
      set_op(2, -13, 9);
      req = 4'b0101;
      w = model_pick(req, model_ptr);
      exp = model_prod(a_op[w], b_op[w]);
      model_ptr = (w + 1) % NUM_REQ;
      @(posedge clk); #1;
      set_op(w, 55, 55);
      req[w] = 1'b0;
      wait_resp("drop_req", n);
      expect_resp("drop_req", w, exp, n, W);
      w2 = model_pick(req, model_ptr);
      exp = model_prod(a_op[w2], b_op[w2]);
      model_ptr = (w2 + 1) % NUM_REQ;
      wait_resp("after_drop", n);
      expect_resp("after_drop", w2, exp, n, W + 2);
      req = '0;
      @(posedge clk); #1;
   endtask

   task automatic test_random(input int rounds);
      int w;
      int n;
      logic [PW-1:0] exp;
      do_reset();
      for (int i = 0; i < NUM_REQ; i++) begin
         set_op(i, rand_op(), rand_op());
         req[i] = 1'($urandom_range(1));
      end
      if (req == '0) req[$urandom_range(NUM_REQ - 1)] = 1'b1;
      for (int k = 0; k < rounds; k++) begin
         w = model_pick(req, model_ptr);
         exp = model_prod(a_op[w], b_op[w]);
         model_ptr = (w + 1) % NUM_REQ;
         wait_resp("random", n);
         expect_resp("random", w, exp, n, (k == 0) ? W + 1 : W + 2);
         req[w] = 1'b0;
         for (int i = 0; i < NUM_REQ; i++) begin
            if (!req[i] && $urandom_range(1) == 1) begin
               set_op(i, rand_op(), rand_op());
               req[i] = 1'b1;
            end
         end
         if (req == '0) begin
            w = int'($urandom_range(NUM_REQ - 1));
            set_op(w, rand_op(), rand_op());
            req[w] = 1'b1;
         end
      end
      req = '0;
      @(posedge clk); #1;
   endtask

   initial begin
      reset = 1'b1;
      req = '0;
      a_value = '0;
      b_value = '0;
      test_reset();
      test_products();
      test_arbitration("rr_all", 4'b1111, 5);
      test_arbitration("rr_pair", 4'b0101, 4);
      test_reset_mid_run();
      test_drop_after_grant();
      test_random(60);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
